qdi_bin_bridge: RTL and testbench

- Clocked bridge between binary bench/logic and quasi-delay-insensitive (QDI) enable-based 1-of-N channels.
- Contains three sub-blocks:
  - a binary-to-e1of4 data sender, 2-bit value onto Tx[3:0];
  - a binary-to-e1of3 control sender, 2-bit value onto Cx[2:0];
  - an e1of4-to-binary receiver, Rx[3:0] to 2-bit value plus valid.
- Sits between synchronous stimulus/checking logic and asynchronous QDI blocks such as a register cell.

---
 rtl/qdi_bin_bridge_if.sv | 24 ++
 rtl/qdi_bin_bridge.sv | 98 +++++++++
 tb/tb_qdi_bin_bridge.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/qdi_bin_bridge_if.sv
// qdi_bin_bridge_if: binary-side controls plus the e1of4/e1of3 QDI channel rails of the bridge.
// master is the bridge itself; slave is the surrounding bench/QDI environment.
interface qdi_bin_bridge_if;
    logic       go;
    logic [1:0] tx_data;
    logic [1:0] ctrl_data;
    logic       ready;
    logic [3:0] tx;
    logic       txe;
    logic [2:0] cx;
    logic       cxe;
    logic [3:0] rx;
    logic       rxe;
    logic [1:0] rx_data;
    logic       rx_valid;
    modport master (
        input  go, tx_data, ctrl_data, txe, cxe, rx,
        output ready, tx, cx, rxe, rx_data, rx_valid
    );
    modport slave (
        output go, tx_data, ctrl_data, txe, cxe, rx,
        input  ready, tx, cx, rxe, rx_data, rx_valid
    );
endinterface

// File: rtl/qdi_bin_bridge.sv
// qdi_bin_bridge: clocked bridge between binary logic and e1of4/e1of3 QDI channels.
// Two 4-phase senders (control Cx, data Tx) share one launch; an independent e1of4 receiver.
module qdi_bin_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    qdi_bin_bridge_if.master  bus,
    inout  wire               VDD,
    inout  wire               GND
);
    typedef enum logic [1:0] {IDLE, SEND, NEUTRAL} send_t;
    typedef enum logic {READY, HOLD} recv_t;
    logic [5:0] sync_q [SYNC_STAGES];
    logic       txe_s;
    logic       cxe_s;
    logic [3:0] rx_s;
    logic       armed;
    logic       launch;
    logic [1:0] idle;
    logic [1:0] start;
    logic [1:0] en;
    logic [3:0] code [2];
    logic [3:0] rails [2];
    recv_t      r_q;
    recv_t      r_d;
    logic [1:0] rx_data_q;
    logic [1:0] rx_data_d;
    logic       rx_onehot;
    logic       unused_bits;
    assign unused_bits = ^{VDD, GND, rails[0][3]};
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus.rx, bus.cxe, bus.txe};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    assign {rx_s, cxe_s, txe_s} = sync_q[SYNC_STAGES-1];
    // Txe only matters when the data channel will actually be used.
    assign bus.ready = armed & (&idle) & cxe_s & (bus.ctrl_data == 2'd0 | txe_s);
    assign launch    = bus.go & bus.ready;
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) armed <= 1'b0;
        else        armed <= !bus.go | (armed & !launch);
    assign start   = {launch & (bus.ctrl_data != 2'd0), launch};
    assign en      = {txe_s, cxe_s};
    assign code[0] = bus.ctrl_data == 2'd3 ? 4'b0100 : 4'b0001 << bus.ctrl_data;
    assign code[1] = 4'b0001 << bus.tx_data;
    // Channel 0 drives Cx, channel 1 drives Tx; each is a 4-phase IDLE/SEND/NEUTRAL sender.
    for (genvar g = 0; g < 2; g++) begin : ch
        send_t      s_q;
        send_t      s_d;
        logic [3:0] rail_q;
        logic [3:0] rail_d;
        always_ff @(posedge CLK or negedge RESET)
            if (!RESET) begin
                s_q    <= IDLE;
                rail_q <= '0;
            end else begin
                s_q    <= s_d;
                rail_q <= rail_d;
            end
        always_comb begin
            s_d    = s_q;
            rail_d = rail_q;
            if (s_q == IDLE && start[g]) begin
                s_d    = SEND;
                rail_d = code[g];
            end else if (s_q == SEND && !en[g]) begin
                s_d    = NEUTRAL;
                rail_d = '0;
            end else if (s_q == NEUTRAL && en[g]) begin
                s_d    = IDLE;
            end
        end
        assign idle[g]  = s_q == IDLE;
        assign rails[g] = rail_q;
    end
    assign bus.cx = rails[0][2:0];
    assign bus.tx = rails[1];
    assign rx_onehot = rx_s != 4'd0 && (rx_s & (rx_s - 4'd1)) == 4'd0;
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            r_q       <= READY;
            rx_data_q <= 2'd0;
        end else begin
            r_q       <= r_d;
            rx_data_q <= rx_data_d;
        end
    always_comb begin
        r_d       = r_q == READY ? (rx_onehot ? HOLD : READY) : (rx_s == 4'd0 ? READY : HOLD);
        rx_data_d = (r_q == READY && rx_onehot) ? {rx_s[3] | rx_s[2], rx_s[3] | rx_s[1]} : rx_data_q;
    end
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = r_q == HOLD;
    assign bus.rxe      = r_q == READY;
endmodule

// File: tb/tb_qdi_bin_bridge.sv
// tb_qdi_bin_bridge: directed bench for qdi_bin_bridge, enables and Rx rails driven by hand.
module tb_qdi_bin_bridge;
    logic clk;
    logic rst_n;
    wire  vdd = 1'b1;
    wire  gnd = 1'b0;
    int   checks = 0;
    int   failures = 0;
    qdi_bin_bridge_if bus ();
    qdi_bin_bridge #(.SYNC_STAGES(2)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus),
        .VDD   (vdd),
        .GND   (gnd)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic token(input logic [1:0] td, input logic [1:0] cd,
                         input logic [2:0] exp_cx, input logic [3:0] exp_tx);
        bus.tx_data   = td;
        bus.ctrl_data = cd;
        bus.go        = 1'b1;
        wait_cyc(3);
        check("tok_cx", 8'(bus.cx), 8'(exp_cx));
        check("tok_tx", 8'(bus.tx), 8'(exp_tx));
        bus.cxe = 1'b0;
        bus.txe = 1'b0;
        wait_cyc(5);
        check("tok_clr", {1'b0, bus.cx, bus.tx}, 8'h00);
        bus.cxe = 1'b1;
        bus.txe = 1'b1;
        wait_cyc(5);
        check("tok_no_second", {1'b0, bus.cx, bus.tx}, 8'h00);
        bus.go = 1'b0;
        wait_cyc(2);
        check("tok_ready", 8'(bus.ready), 8'h01);
    endtask
    initial begin
        rst_n         = 1'b0;
        bus.go        = 1'b0;
        bus.tx_data   = 2'd0;
        bus.ctrl_data = 2'd0;
        bus.txe       = 1'b1;
        bus.cxe       = 1'b1;
        bus.rx        = 4'd0;
        wait_cyc(3);
        check("rst_tx", 8'(bus.tx), 8'h00);
        check("rst_cx", 8'(bus.cx), 8'h00);
        check("rst_rxe", 8'(bus.rxe), 8'h01);
        check("rst_rx_valid", 8'(bus.rx_valid), 8'h00);
        check("rst_rx_data", 8'(bus.rx_data), 8'h00);
        rst_n = 1'b1;
        wait_cyc(5);
        check("post_rst_ready", 8'(bus.ready), 8'h01);
        check("post_rst_rails", {1'b0, bus.cx, bus.tx}, 8'h00);
        // (3,1): Cx[1] and Tx[3]; later data changes must not disturb the rails
        bus.tx_data   = 2'd3;
        bus.ctrl_data = 2'd1;
        bus.go        = 1'b1;
        wait_cyc(3);
        check("l1_cx", 8'(bus.cx), 8'h02);
        check("l1_tx", 8'(bus.tx), 8'h08);
        check("l1_ready", 8'(bus.ready), 8'h00);
        bus.tx_data   = 2'd0;
        bus.ctrl_data = 2'd2;
        wait_cyc(2);
        check("l1_hold_cx", 8'(bus.cx), 8'h02);
        check("l1_hold_tx", 8'(bus.tx), 8'h08);
        bus.cxe = 1'b0;
        bus.txe = 1'b0;
        wait_cyc(5);
        check("l1_clr_cx", 8'(bus.cx), 8'h00);
        check("l1_clr_tx", 8'(bus.tx), 8'h00);
        bus.cxe = 1'b1;
        bus.txe = 1'b1;
        wait_cyc(5);
        check("l1_go_held_cx", 8'(bus.cx), 8'h00);
        check("l1_go_held_tx", 8'(bus.tx), 8'h00);
        check("l1_go_held_ready", 8'(bus.ready), 8'h00);
        bus.go = 1'b0;
        wait_cyc(2);
        check("l1_rearm_ready", 8'(bus.ready), 8'h01);
        // read-only token: data channel idle, Txe irrelevant
        bus.ctrl_data = 2'd0;
        bus.tx_data   = 2'd2;
        bus.txe       = 1'b0;
        wait_cyc(5);
        check("rd_ready_txe0", 8'(bus.ready), 8'h01);
        bus.go = 1'b1;
        wait_cyc(3);
        check("rd_cx", 8'(bus.cx), 8'h01);
        check("rd_tx", 8'(bus.tx), 8'h00);
        bus.cxe = 1'b0;
        wait_cyc(5);
        check("rd_clr_cx", 8'(bus.cx), 8'h00);
        bus.go  = 1'b0;
        bus.cxe = 1'b1;
        wait_cyc(5);
        check("rd_ready_again", 8'(bus.ready), 8'h01);
        bus.ctrl_data = 2'd1;
        #1;
        check("wr_needs_txe", 8'(bus.ready), 8'h00);
        bus.txe = 1'b1;
        wait_cyc(5);
        check("wr_txe_back", 8'(bus.ready), 8'h01);
        // full write/read sequence, plus clamped control code 3
        token(2'd3, 2'd1, 3'b010, 4'b1000);
        token(2'd2, 2'd1, 3'b010, 4'b0100);
        token(2'd0, 2'd1, 3'b010, 4'b0001);
        token(2'd1, 2'd1, 3'b010, 4'b0010);
        token(2'd0, 2'd0, 3'b001, 4'b0000);
        token(2'd1, 2'd2, 3'b100, 4'b0010);
        token(2'd0, 2'd0, 3'b001, 4'b0000);
        token(2'd2, 2'd3, 3'b100, 4'b0100);
        // receiver
        bus.rx = 4'b0100;
        wait_cyc(5);
        check("rx2_data", 8'(bus.rx_data), 8'h02);
        check("rx2_valid", 8'(bus.rx_valid), 8'h01);
        check("rx2_rxe", 8'(bus.rxe), 8'h00);
        bus.rx = 4'b0000;
        wait_cyc(5);
        check("rx_neutral_valid", 8'(bus.rx_valid), 8'h00);
        check("rx_neutral_rxe", 8'(bus.rxe), 8'h01);
        check("rx_neutral_data", 8'(bus.rx_data), 8'h02);
        bus.rx = 4'b0110;
        wait_cyc(5);
        check("rx_multi_valid", 8'(bus.rx_valid), 8'h00);
        check("rx_multi_rxe", 8'(bus.rxe), 8'h01);
        check("rx_multi_data", 8'(bus.rx_data), 8'h02);
        bus.rx = 4'b0000;
        wait_cyc(5);
        bus.rx = 4'b1000;
        wait_cyc(5);
        check("rx3_data", 8'(bus.rx_data), 8'h03);
        check("rx3_valid", 8'(bus.rx_valid), 8'h01);
        bus.rx = 4'b0000;
        wait_cyc(5);
        bus.rx = 4'b0001;
        wait_cyc(5);
        check("rx0_data", 8'(bus.rx_data), 8'h00);
        check("rx0_rxe", 8'(bus.rxe), 8'h00);
        // reset in the middle of a handshake, receiver still holding
        bus.tx_data   = 2'd1;
        bus.ctrl_data = 2'd2;
        bus.go        = 1'b1;
        wait_cyc(3);
        check("mid_cx", 8'(bus.cx), 8'h04);
        check("mid_tx", 8'(bus.tx), 8'h02);
        #2;
        rst_n  = 1'b0;
        bus.rx = 4'b0000;
        #1;
        check("async_cx", 8'(bus.cx), 8'h00);
        check("async_tx", 8'(bus.tx), 8'h00);
        check("async_rxe", 8'(bus.rxe), 8'h01);
        check("async_rx_valid", 8'(bus.rx_valid), 8'h00);
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(5);
        check("disarmed_ready", 8'(bus.ready), 8'h00);
        check("disarmed_rails", {1'b0, bus.cx, bus.tx}, 8'h00);
        bus.go = 1'b0;
        wait_cyc(5);
        check("rearmed_ready", 8'(bus.ready), 8'h01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
